// File: rtl/pulse_sync_scheduler.sv
// pulse_sync_scheduler
//   Time-shares one single-pulse CDC synchronizer between P_NUM_REQ event
//   sources in the clk_a domain. Incoming event pulses are latched as pending
//   flags. One pending source is picked round-robin and issued as a one-cycle
//   pulse plus a source ID. A guard gap then follows before the next issue.
//
// Ports
//   i_clk_a      clock, domain A
//   i_rst_a      asynchronous, active-high reset
//   i_req_a      per-source single-cycle event pulses
//   i_ack_async  raw far-domain handshake ack (only with SYNC_SCHED_ACK_EN)
//   o_pend_a     pending flag per source
//   o_single_a   one-cycle pulse to the synchronizer input
//   o_id_a       ID of the last issued source, held until the next issue
//   o_busy_a     high while the FSM is not idle
//   o_drop_a     one-cycle flag per source: event lost, source already pending
//
// Optional feature macro: SYNC_SCHED_ACK_EN
//   When defined, the gap also waits for a synchronized ack rise-then-fall,
//   observed after the issue edge. The counter saturates while it waits.

module pulse_sync_scheduler #(
  parameter int unsigned P_NUM_REQ    = 4,
  parameter int unsigned P_ID_W       = 2,
  parameter int unsigned P_GAP_CYCLES = 8
) (
  input  logic                 i_clk_a,
  input  logic                 i_rst_a,
  input  logic [P_NUM_REQ-1:0] i_req_a,
`ifdef SYNC_SCHED_ACK_EN
  input  logic                 i_ack_async,
`endif
  output logic [P_NUM_REQ-1:0] o_pend_a,
  output logic                 o_single_a,
  output logic [P_ID_W-1:0]    o_id_a,
  output logic                 o_busy_a,
  output logic [P_NUM_REQ-1:0] o_drop_a
);

  localparam int unsigned          CNT_W    = $clog2(P_GAP_CYCLES) + 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(P_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [P_ID_W-1:0]    LAST_RST = P_ID_W'(P_NUM_REQ - 1);
  localparam logic [P_NUM_REQ-1:0] ONE_HOT0 = P_NUM_REQ'(1);

  typedef enum logic {
    S_IDLE,
    S_GAP
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [P_NUM_REQ-1:0]   pend_q, pend_d;
  logic [P_NUM_REQ-1:0]   drop_q, drop_d;
  logic [P_ID_W-1:0]      last_q, last_d;
  logic [P_ID_W-1:0]      id_q, id_d;
  logic                   single_q, single_d;
  logic                   busy_q, busy_d;

  logic                   grant_vld;
  logic [P_ID_W-1:0]      grant_id;
  logic [P_NUM_REQ-1:0]   grant_oh;
  logic [P_NUM_REQ-1:0]   issue_oh;
  logic                   issue;
  logic                   ack_done;
  int unsigned            idx;

  // Round-robin search: offsets 1..N from the last grant. The first pending
  // source found wins, so the last-granted source has the lowest priority.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    grant_oh  = '0;
    idx       = 0;
    for (int unsigned i = 1; i <= P_NUM_REQ; i++) begin
      idx = (32'(last_q) + i) % P_NUM_REQ;
      if (!grant_vld && (|(pend_q & (ONE_HOT0 << idx)))) begin
        grant_vld = 1'b1;
        grant_id  = P_ID_W'(idx);
        grant_oh  = ONE_HOT0 << idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    id_d     = id_q;
    single_d = 1'b0;
    issue    = 1'b0;
    issue_oh = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          issue    = 1'b1;
          issue_oh = grant_oh;
          single_d = 1'b1;
          id_d     = grant_id;
          last_d   = grant_id;
          cnt_d    = '0;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_LAST && ack_done) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A request arriving on the issue edge of the same source is re-queued
    // rather than dropped.
    pend_d = (pend_q & ~issue_oh) | i_req_a;
    drop_d = i_req_a & pend_q & ~issue_oh;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk_a or posedge i_rst_a) begin
    if (i_rst_a) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pend_q   <= '0;
      drop_q   <= '0;
      last_q   <= LAST_RST;
      id_q     <= '0;
      single_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      last_q   <= last_d;
      id_q     <= id_d;
      single_q <= single_d;
      busy_q   <= busy_d;
    end
  end

`ifdef SYNC_SCHED_ACK_EN
  logic ack_meta_q, ack_meta_d;
  logic ack_sync_q, ack_sync_d;
  logic ack_prev_q, ack_prev_d;
  logic rise_seen_q, rise_seen_d;
  logic fall_seen_q, fall_seen_d;

  // A fall counts only after a rise has been seen since the last issue.
  always_comb begin
    ack_meta_d  = i_ack_async;
    ack_sync_d  = ack_meta_q;
    ack_prev_d  = ack_sync_q;
    rise_seen_d = rise_seen_q | (ack_sync_q & ~ack_prev_q);
    fall_seen_d = fall_seen_q | (rise_seen_q & ~ack_sync_q & ack_prev_q);
    if (issue) begin
      rise_seen_d = 1'b0;
      fall_seen_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk_a or posedge i_rst_a) begin
    if (i_rst_a) begin
      ack_meta_q  <= 1'b0;
      ack_sync_q  <= 1'b0;
      ack_prev_q  <= 1'b0;
      rise_seen_q <= 1'b0;
      fall_seen_q <= 1'b0;
    end else begin
      ack_meta_q  <= ack_meta_d;
      ack_sync_q  <= ack_sync_d;
      ack_prev_q  <= ack_prev_d;
      rise_seen_q <= rise_seen_d;
      fall_seen_q <= fall_seen_d;
    end
  end

  assign ack_done = fall_seen_q;
`else
  assign ack_done = 1'b1;
`endif

  assign o_pend_a   = pend_q;
  assign o_single_a = single_q;
  assign o_id_a     = id_q;
  assign o_busy_a   = busy_q;
  assign o_drop_a   = drop_q;

endmodule

// File: tb/tb_pulse_sync_scheduler.sv
// Directed bench for pulse_sync_scheduler (default build, timer-only gap).
// Expected issue IDs are pushed to a scoreboard queue as stimulus is driven.
// A negedge monitor pops the queue and checks each o_single_a pulse.

module tb_pulse_sync_scheduler;

  localparam int unsigned P_N   = 4;
  localparam int unsigned P_IDW = 2;
  localparam int unsigned P_GAP = 8;

  logic             i_clk_a = 1'b0;
  logic             i_rst_a;
  logic [P_N-1:0]   i_req_a;
  logic [P_N-1:0]   o_pend_a;
  logic             o_single_a;
  logic [P_IDW-1:0] o_id_a;
  logic             o_busy_a;
  logic [P_N-1:0]   o_drop_a;

  int               n_assert = 0;
  int               n_fail   = 0;
  int               cycle    = 0;
  logic [P_IDW-1:0] sb[$];
  logic [P_N-1:0]   drop_acc = '0;
  logic             prev_single = 1'b0;

  function automatic void check(input string tag, input logic ok);
    n_assert++;
    if (ok !== 1'b1) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endfunction

  pulse_sync_scheduler #(
    .P_NUM_REQ   (P_N),
    .P_ID_W      (P_IDW),
    .P_GAP_CYCLES(P_GAP)
  ) dut (
    .i_clk_a   (i_clk_a),
    .i_rst_a   (i_rst_a),
    .i_req_a   (i_req_a),
    .o_pend_a  (o_pend_a),
    .o_single_a(o_single_a),
    .o_id_a    (o_id_a),
    .o_busy_a  (o_busy_a),
    .o_drop_a  (o_drop_a)
  );

  always #5 i_clk_a = ~i_clk_a;

  always @(posedge i_clk_a) cycle++;

  // Scoreboard monitor: every pulse must match the oldest expected ID.
  always @(negedge i_clk_a) begin
    logic [P_IDW-1:0] exp_id;
    if (!i_rst_a) begin
      drop_acc = drop_acc | o_drop_a;
      if (o_single_a) begin
        check("pulse_width_one", prev_single === 1'b0);
        check("sb_expected_pulse", sb.size() != 0);
        if (sb.size() != 0) begin
          exp_id = sb.pop_front();
          check("issue_id", o_id_a === exp_id);
        end
      end
      prev_single = o_single_a;
    end else begin
      prev_single = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge: request is sampled on the next posedge, then cleared.
  task automatic pulse(input logic [P_N-1:0] r);
    i_req_a = r;
    @(negedge i_clk_a);
    i_req_a = '0;
  endtask

  task automatic wait_pulse(output int cyc);
    int n = 0;
    while (!o_single_a && n < 40) begin
      @(negedge i_clk_a);
      n++;
    end
    check("pulse_timeout", o_single_a === 1'b1);
    cyc = cycle;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy_a && n < 60) begin
      @(negedge i_clk_a);
      n++;
    end
    check("idle_timeout", o_busy_a === 1'b0);
    @(negedge i_clk_a);
  endtask

  initial begin
    int c[4];
    int busy_cnt;
    int pulses;

    i_rst_a = 1'b1;
    i_req_a = '0;
    repeat (3) @(negedge i_clk_a);
    i_rst_a = 1'b0;

    // Reset state
    check("rst_pend", o_pend_a === 4'b0000);
    check("rst_single", o_single_a === 1'b0);
    check("rst_id", o_id_a === 2'd0);
    check("rst_busy", o_busy_a === 1'b0);
    check("rst_drop", o_drop_a === 4'b0000);

    // All four sources at once: grants 0,1,2,3 spaced P_GAP+1 cycles apart
    drop_acc = '0;
    sb.push_back(2'd0); sb.push_back(2'd1); sb.push_back(2'd2); sb.push_back(2'd3);
    pulse(4'b1111);
    check("all_pend", o_pend_a === 4'b1111);
    for (int i = 0; i < 4; i++) begin
      wait_pulse(c[i]);
      @(negedge i_clk_a);
    end
    for (int i = 1; i < 4; i++) begin
      check("backlog_spacing", (c[i] - c[i-1]) === int'(P_GAP + 1));
    end
    wait_idle();
    check("all_no_drop", drop_acc === 4'b0000);
    check("all_pend_clear", o_pend_a === 4'b0000);

    // Single request from source 2: two-cycle latency, gap length, pend clears
    sb.push_back(2'd2);
    pulse(4'b0100);
    check("t1_pend_set", o_pend_a === 4'b0100);
    check("t1_no_single_yet", o_single_a === 1'b0);
    @(negedge i_clk_a);
    check("t1_single", o_single_a === 1'b1);
    check("t1_id", o_id_a === 2'd2);
    check("t1_pend_clr", o_pend_a === 4'b0000);
    busy_cnt = 0;
    while (o_busy_a && busy_cnt < 50) begin
      busy_cnt++;
      @(negedge i_clk_a);
      if (o_busy_a) begin
        check("t1_id_stable", o_id_a === 2'd2);
      end
    end
    check("t1_busy_len", busy_cnt === int'(P_GAP));
    check("t1_pend_end", o_pend_a === 4'b0000);
    @(negedge i_clk_a);

    // Source 1 pulses twice during a gap: one drop, only one ID-1 issue
    drop_acc = '0;
    sb.push_back(2'd0);
    pulse(4'b0001);
    @(negedge i_clk_a);
    check("t3_in_gap", o_busy_a === 1'b1);
    sb.push_back(2'd1);
    pulse(4'b0010);
    check("t3_pend1", o_pend_a === 4'b0010);
    check("t3_no_drop_first", o_drop_a === 4'b0000);
    pulse(4'b0010);
    check("t3_drop1", o_drop_a === 4'b0010);
    @(negedge i_clk_a);
    check("t3_drop_one_cycle", o_drop_a === 4'b0000);
    wait_idle();
    wait_idle();
    repeat (12) @(negedge i_clk_a);
    check("t3_sb_drained", sb.size() === 0);

    // Source 3 requests again on its own issue edge: re-queued, no drop
    drop_acc = '0;
    sb.push_back(2'd3); sb.push_back(2'd3);
    pulse(4'b1000);
    pulse(4'b1000);
    check("t4_single", o_single_a === 1'b1);
    check("t4_pend_kept", o_pend_a === 4'b1000);
    check("t4_no_drop", o_drop_a === 4'b0000);
    @(negedge i_clk_a);
    wait_idle();
    wait_idle();
    check("t4_sb_drained", sb.size() === 0);
    check("t4_no_drop_total", drop_acc === 4'b0000);

    // Last grant = 2, then sources 0 and 2 together: order wraps to 0 first
    sb.push_back(2'd2);
    pulse(4'b0100);
    @(negedge i_clk_a);
    wait_idle();
    sb.push_back(2'd0); sb.push_back(2'd2);
    pulse(4'b0101);
    @(negedge i_clk_a);
    wait_idle();
    wait_idle();
    check("t5_sb_drained", sb.size() === 0);

    // Reset during the third gap cycle with sources 1 and 3 pending
    sb.push_back(2'd0);
    pulse(4'b0001);
    pulse(4'b1010);
    check("t6_issue0", o_single_a === 1'b1);
    @(negedge i_clk_a);
    @(negedge i_clk_a);
    check("t6_pend_before", o_pend_a === 4'b1010);
    i_rst_a = 1'b1;
    #1;
    check("t6_rst_pend", o_pend_a === 4'b0000);
    check("t6_rst_single", o_single_a === 1'b0);
    check("t6_rst_id", o_id_a === 2'd0);
    check("t6_rst_busy", o_busy_a === 1'b0);
    check("t6_rst_drop", o_drop_a === 4'b0000);
    @(negedge i_clk_a);
    i_rst_a = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge i_clk_a);
      if (o_single_a) pulses++;
    end
    check("t6_no_pulse_after_rst", pulses === 0);
    check("t6_pend_idle", o_pend_a === 4'b0000);

    // Pointer reset: source 0 wins first again
    sb.push_back(2'd0); sb.push_back(2'd3);
    pulse(4'b1001);
    @(negedge i_clk_a);
    wait_idle();
    wait_idle();
    check("final_sb_empty", sb.size() === 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
